// File: rtl/gr8_bus_pkg.sv
// Shared bus-phase state encoding, card register offsets and strobe decode
// for the GR8RAM bus sequencer.
package gr8_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_2    = 3'd2,
        S_3    = 3'd3,
        S_4    = 3'd4,
        S_5    = 3'd5,
        S_6    = 3'd6,
        S_7    = 3'd7
    } bus_state_e;

    localparam logic [3:0]  REG_BANK  = 4'hF;
    localparam logic [3:0]  REG_SET   = 4'hE;
    localparam logic [3:0]  REG_RAM   = 4'h3;
    localparam logic [3:0]  REG_ADDRH = 4'h2;
    localparam logic [3:0]  REG_ADDRM = 4'h1;
    localparam logic [3:0]  REG_ADDRL = 4'h0;
    localparam logic [10:0] CFFF_ADDR = 11'h7FF;

    typedef struct packed {
        logic bank;
        logic set;
        logic ram;
        logic addrh;
        logic addrm;
        logic addrl;
    } strobe_t;

    // One-hot by construction: each offset maps to at most one strobe.
    function automatic strobe_t decode_strobe(input logic [3:0] off, input logic sel,
                                              input logic wr);
        strobe_t st;
        st = '0;
        if (sel) begin
            case (off)
                REG_BANK:  st.bank  = wr;
                REG_SET:   st.set   = wr;
                REG_RAM:   st.ram   = 1'b1;
                REG_ADDRH: st.addrh = wr;
                REG_ADDRM: st.addrm = wr;
                REG_ADDRL: st.addrl = wr;
                default:   st = '0;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/gr8_ref_ctr.sv
// Refresh-slot pacing counter: wraps every REF_PERIOD bus cycles and flags
// the slot where the count is zero.
module gr8_ref_ctr
    import gr8_bus_pkg::*;
#(
    parameter int REF_PERIOD = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic ref_req
);
    localparam int RW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REF_PERIOD - 1);

    logic [RW-1:0] ref_d, ref_q;

    always_comb begin
        ref_d = ref_q;
        if (adv) ref_d = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ref_q <= '0;
        else     ref_q <= ref_d;
    end

    assign ref_req = (ref_q == '0);

endmodule

// File: rtl/gr8_bus_seq.sv
// Apple II bus-phase sequencer: PHI1-locked state counter, bus/ROM enables,
// card enable flags and registered register-select strobes.
// Optional macro GR8_CFFF_RELEASE_EN: $CFFF strobe access releases IOROMEN.
module gr8_bus_seq
    import gr8_bus_pkg::*;
#(
    parameter int REF_PERIOD = 13
) (
    input  logic        C7M,
    input  logic        RES,
    input  logic        PHI1,
    input  logic        nDEVSEL,
    input  logic        nIOSEL,
    input  logic        nIOSTRB,
    input  logic        nWE,
    input  logic [10:0] A,
    output logic [2:0]  S,
    output logic        PHI0seen,
    output logic        RefReq,
    output logic        DBEN,
    output logic        RDCSEN,
    output logic        WRCSEN,
    output logic        REGEN,
    output logic        IOROMEN,
    output logic        BankWR,
    output logic        SetWR,
    output logic        AddrHWR,
    output logic        AddrMWR,
    output logic        AddrLWR,
    output logic        RAMSEL
);
    bus_state_e s_d, s_q;
    logic       phi1reg_q;
    logic       phi0seen_d, phi0seen_q;
    logic       dben_d, dben_q;
    logic       wrcsen_d, wrcsen_q;
    logic       regen_d, regen_q;
    logic       ioromen_d, ioromen_q;
    strobe_t    strb_d, strb_q;
    logic       phi1_rise;

    always_comb begin
        // A rise only counts once a low PHI1 has been seen, so reset while
        // PHI1 is high cannot produce a false sync.
        phi1_rise  = PHI1 & ~phi1reg_q & phi0seen_q;
        phi0seen_d = phi0seen_q | ~PHI1;

        s_d = s_q;
        if (phi1_rise)            s_d = S_1;
        else if (s_q == S_IDLE)   s_d = S_IDLE;
        else if (s_q == S_7)      s_d = S_7;
        else                      s_d = bus_state_e'(s_q + 3'd1);

        dben_d   = (s_d == S_5) || (s_d == S_6) || (s_d == S_7);
        wrcsen_d = (s_d == S_6) || (s_d == S_7);

        regen_d   = regen_q;
        ioromen_d = ioromen_q;
        if ((s_q == S_4) && !nIOSEL) begin
            regen_d   = 1'b1;
            ioromen_d = 1'b1;
        end
`ifdef GR8_CFFF_RELEASE_EN
        if ((s_q == S_3) && !nIOSTRB && (A == CFFF_ADDR)) ioromen_d = 1'b0;
`endif

        // Strobes use pre-edge REGEN, so the enabling IOSEL cycle itself
        // never strobes; a short cycle clears them via the S1 entry.
        strb_d = strb_q;
        if (s_d == S_1)
            strb_d = '0;
        else if (s_q == S_4)
            strb_d = decode_strobe(A[3:0], ~nDEVSEL & regen_q, ~nWE);
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            s_q        <= S_IDLE;
            phi1reg_q  <= 1'b0;
            phi0seen_q <= 1'b0;
            dben_q     <= 1'b0;
            wrcsen_q   <= 1'b0;
            regen_q    <= 1'b0;
            ioromen_q  <= 1'b0;
            strb_q     <= '0;
        end else begin
            s_q        <= s_d;
            phi1reg_q  <= PHI1;
            phi0seen_q <= phi0seen_d;
            dben_q     <= dben_d;
            wrcsen_q   <= wrcsen_d;
            regen_q    <= regen_d;
            ioromen_q  <= ioromen_d;
            strb_q     <= strb_d;
        end
    end

    gr8_ref_ctr #(.REF_PERIOD(REF_PERIOD)) u_ref_ctr (
        .clk     (C7M),
        .rst     (RES),
        .adv     (s_q == S_3),
        .ref_req (RefReq)
    );

    assign S        = s_q;
    assign PHI0seen = phi0seen_q;
    assign DBEN     = dben_q;
    assign RDCSEN   = dben_q;
    assign WRCSEN   = wrcsen_q;
    assign REGEN    = regen_q;
    assign IOROMEN  = ioromen_q;
    assign BankWR   = strb_q.bank;
    assign SetWR    = strb_q.set;
    assign RAMSEL   = strb_q.ram;
    assign AddrHWR  = strb_q.addrh;
    assign AddrMWR  = strb_q.addrm;
    assign AddrLWR  = strb_q.addrl;

endmodule

// File: tb/tb_gr8_bus_seq.sv
// Directed bench for gr8_bus_seq: a per-edge reference model queues the
// expected outputs of each bus cycle, which are popped as the DUT steps.
module tb_gr8_bus_seq;
    localparam int REF_PERIOD = 13;

    typedef struct packed {
        logic [2:0] s;
        logic phi0seen, refreq, dben, rdcsen, wrcsen, regen, ioromen;
        logic bank, set, ram, addrh, addrm, addrl;
    } obs_t;

    logic C7M = 1'b0;
    logic RES, PHI1, nDEVSEL, nIOSEL, nIOSTRB, nWE;
    logic [10:0] A;
    logic [2:0] S;
    logic PHI0seen, RefReq, DBEN, RDCSEN, WRCSEN, REGEN, IOROMEN;
    logic BankWR, SetWR, AddrHWR, AddrMWR, AddrLWR, RAMSEL;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ref_hits = 0;
    int ref_m = 0;
    logic regen_m = 1'b0;
    logic ioromen_m = 1'b0;
    obs_t exp_q[$];

    always #5 C7M = ~C7M;

    gr8_bus_seq #(.REF_PERIOD(REF_PERIOD)) dut (
        .C7M(C7M), .RES(RES), .PHI1(PHI1), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL),
        .nIOSTRB(nIOSTRB), .nWE(nWE), .A(A), .S(S), .PHI0seen(PHI0seen),
        .RefReq(RefReq), .DBEN(DBEN), .RDCSEN(RDCSEN), .WRCSEN(WRCSEN),
        .REGEN(REGEN), .IOROMEN(IOROMEN), .BankWR(BankWR), .SetWR(SetWR),
        .AddrHWR(AddrHWR), .AddrMWR(AddrMWR), .AddrLWR(AddrLWR), .RAMSEL(RAMSEL)
    );

    function automatic obs_t sample();
        obs_t o;
        o = '{s: S, phi0seen: PHI0seen, refreq: RefReq, dben: DBEN, rdcsen: RDCSEN,
              wrcsen: WRCSEN, regen: REGEN, ioromen: IOROMEN, bank: BankWR,
              set: SetWR, ram: RAMSEL, addrh: AddrHWR, addrm: AddrMWR, addrl: AddrLWR};
        return o;
    endfunction

    task automatic tick();
        @(posedge C7M);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // One bus cycle of n edges: PHI1 high for edges 1..3, low afterwards.
    task automatic run_cycle(input int n, input logic [10:0] a, input logic dev_n,
                             input logic ios_n, input logic strb_n, input logic we_n);
        obs_t e;
        logic pre_regen;
        logic sel;
        logic st_bank, st_set, st_ram, st_h, st_m, st_l;
        cyc++;
        A = a; nDEVSEL = dev_n; nIOSEL = ios_n; nIOSTRB = strb_n; nWE = we_n;
        pre_regen = regen_m;
        sel = ~dev_n & pre_regen;
        st_bank = sel & ~we_n & (a[3:0] == 4'hF);
        st_set  = sel & ~we_n & (a[3:0] == 4'hE);
        st_ram  = sel & (a[3:0] == 4'h3);
        st_h    = sel & ~we_n & (a[3:0] == 4'h2);
        st_m    = sel & ~we_n & (a[3:0] == 4'h1);
        st_l    = sel & ~we_n & (a[3:0] == 4'h0);
        for (int k = 1; k <= n; k++) begin
            if (k == 4) begin
                ref_m = (ref_m == REF_PERIOD - 1) ? 0 : ref_m + 1;
`ifdef GR8_CFFF_RELEASE_EN
                if (!strb_n && a == 11'h7FF) ioromen_m = 1'b0;
`endif
            end
            if (k == 5 && !ios_n) begin
                regen_m = 1'b1;
                ioromen_m = 1'b1;
            end
            e = '0;
            e.s = (k > 7) ? 3'd7 : 3'(k);
            e.phi0seen = 1'b1;
            e.refreq = (ref_m == 0);
            e.dben = (k >= 5);
            e.rdcsen = (k >= 5);
            e.wrcsen = (k >= 6);
            e.regen = regen_m;
            e.ioromen = ioromen_m;
            if (k >= 5) begin
                e.bank = st_bank; e.set = st_set; e.ram = st_ram;
                e.addrh = st_h; e.addrm = st_m; e.addrl = st_l;
            end
            exp_q.push_back(e);
        end
        for (int k = 1; k <= n; k++) begin
            obs_t o;
            PHI1 = (k <= 3);
            tick();
            o = sample();
            if (k == 2 && cyc <= 26 && o.refreq) ref_hits++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $error("FAIL scoreboard_empty: got 0 entries want 1");
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("cyc%0d_edge%0d", cyc, k), 32'(o), 32'(e));
            end
        end
    endtask

    initial begin
        obs_t o;
        RES = 1'b1; PHI1 = 1'b1; nDEVSEL = 1'b1; nIOSEL = 1'b1; nIOSTRB = 1'b1;
        nWE = 1'b1; A = '0;
        repeat (3) tick();
        o = sample(); o.refreq = 1'b0;
        chk("reset_state", 32'(o), 32'(0));

        // PHI1 held high after reset: no PHI0 sample yet, so no sync.
        RES = 1'b0;
        repeat (10) tick();
        chk("nophi0_s", 32'(S), 32'(0));
        chk("nophi0_seen", 32'(PHI0seen), 32'(0));
        PHI1 = 1'b0;
        repeat (4) tick();
        chk("phi0_low_s", 32'(S), 32'(0));
        chk("phi0_low_seen", 32'(PHI0seen), 32'(1));

        // Sync plus 26 refresh-paced cycles.
        for (int c = 0; c < 26; c++) run_cycle(7, 11'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("refresh_hits", 32'(ref_hits), 32'(2));

        run_cycle(7, 11'h00F, 1'b0, 1'b1, 1'b1, 1'b0);  // write before enable
        run_cycle(7, 11'h00F, 1'b0, 1'b0, 1'b1, 1'b0);  // IOSEL + DEVSEL same cycle
        run_cycle(7, 11'h00F, 1'b0, 1'b1, 1'b1, 1'b0);  // BankWR
        run_cycle(7, 11'h003, 1'b0, 1'b1, 1'b1, 1'b1);  // RAMSEL read
        run_cycle(7, 11'h00F, 1'b0, 1'b1, 1'b1, 1'b1);  // read of write-only reg
        run_cycle(7, 11'h00E, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(7, 11'h002, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(7, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(7, 11'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(8, 11'h002, 1'b0, 1'b1, 1'b1, 1'b0);  // long cycle dwells in S7
        run_cycle(5, 11'h00F, 1'b0, 1'b1, 1'b1, 1'b0);  // short cycle cut at S5
        run_cycle(7, 11'h000, 1'b1, 1'b1, 1'b1, 1'b1);
        run_cycle(7, 11'h7FF, 1'b1, 1'b1, 1'b0, 1'b1);  // $CFFF strobe
        chk("cfff_ioromen", 32'(IOROMEN), 32'(ioromen_m));

        // Reset in S5 with BankWR high.
        run_cycle(5, 11'h00F, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_res_bank", 32'(BankWR), 32'(1));
        RES = 1'b1; PHI1 = 1'b0;
        tick();
        o = sample(); o.refreq = 1'b0;
        chk("res_midcycle", 32'(o), 32'(0));
        RES = 1'b0;
        tick();
        chk("res_resync_s", 32'(S), 32'(0));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
